// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the streaming line buffer.
package line_buffer_pkg;

  localparam int unsigned ROW_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // LSB of tap k (k = 1..NUM_TAPS) inside a packed tap/RAM word.
  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned w);
    return (k - 1) * w;
  endfunction

endpackage

// File: rtl/line_buffer_taps_if.sv
// Pixel-stream side of the line buffer: source drives clken/sof/din, buffer returns the window column.
interface line_buffer_taps_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 640,
  parameter int unsigned NUM_TAPS = 2
);
  import line_buffer_pkg::*;

  localparam int unsigned COL_W = clog2(LINE_LEN);

  logic                       clken;
  logic                       sof;
  logic [DATA_W-1:0]          din;
  logic [DATA_W-1:0]          dout_cur;
  logic [NUM_TAPS*DATA_W-1:0] taps;
  logic                       out_vld;
  logic                       taps_full;
  logic [COL_W-1:0]           col_cnt;
  logic [ROW_W-1:0]           row_cnt;

  modport master (
    output clken, sof, din,
    input  dout_cur, taps, out_vld, taps_full, col_cnt, row_cnt
  );

  modport slave (
    input  clken, sof, din,
    output dout_cur, taps, out_vld, taps_full, col_cnt, row_cnt
  );

endinterface

// File: rtl/lb_sdp_ram.sv
// Simple dual-port RAM, one write and one enabled read port, read-first on address collision.
module lb_sdp_ram
  import line_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 640
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_taps.sv
// RAM-based line buffer presenting NUM_TAPS vertically aligned pixels plus the current pixel.
// Define LINE_BUF_BORDER_REPLICATE_EN for top-border replication instead of zero padding.
module line_buffer_taps
  import line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_LEN = 640,
  parameter int unsigned NUM_TAPS = 2
) (
  input  logic               clk,
  input  logic               Reset_n,
  line_buffer_taps_if.slave  bus
);

  localparam int unsigned COL_W  = clog2(LINE_LEN);
  localparam int unsigned FILL_W = clog2(NUM_TAPS + 1);
  localparam int unsigned WORD_W = NUM_TAPS * DATA_W;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(NUM_TAPS);

  logic [COL_W-1:0]  wr_col, pos_col, out_col;
  logic [ROW_W-1:0]  wr_row, pos_row, out_row;
  logic [FILL_W-1:0] fill, pos_fill, out_fill;
  logic [DATA_W-1:0] cur_q;
  logic              vld_q, full_q;
  logic [WORD_W-1:0] rd_word, wr_word, taps_mux;

  // sof re-anchors the accepted pixel at (0,0) with an empty history
  always_comb begin
    pos_col  = bus.sof ? '0 : wr_col;
    pos_row  = bus.sof ? '0 : wr_row;
    pos_fill = bus.sof ? '0 : fill;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      wr_col   <= '0;
      wr_row   <= '0;
      fill     <= '0;
      out_col  <= '0;
      out_row  <= '0;
      out_fill <= '0;
      cur_q    <= '0;
      vld_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      vld_q <= bus.clken;
      if (bus.clken) begin
        cur_q    <= bus.din;
        out_col  <= pos_col;
        out_row  <= pos_row;
        out_fill <= pos_fill;
        full_q   <= (pos_fill == FULL_FILL);
        if (pos_col == LAST_COL) begin
          wr_col <= '0;
          wr_row <= (pos_row == '1) ? pos_row : pos_row + 1'b1;
          fill   <= (pos_fill == FULL_FILL) ? pos_fill : pos_fill + 1'b1;
        end else begin
          wr_col <= pos_col + 1'b1;
          wr_row <= pos_row;
          fill   <= pos_fill;
        end
      end
    end
  end

  // The read for a pixel happens on its accept edge; the shifted word is written back on
  // the following edge, so a column is never read and written with conflicting intent.
  generate
    if (NUM_TAPS == 1) begin : g_one_tap
      assign wr_word = cur_q;
    end else begin : g_multi_tap
      assign wr_word = {rd_word[WORD_W-DATA_W-1:0], cur_q};
    end
  endgenerate

  lb_sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (LINE_LEN)
  ) u_ram (
    .clk   (clk),
    .we    (vld_q),
    .waddr (out_col),
    .wdata (wr_word),
    .re    (bus.clken),
    .raddr (pos_col),
    .rdata (rd_word)
  );

  always_comb begin
    taps_mux = '0;
    for (int unsigned k = 1; k <= NUM_TAPS; k++) begin
      if (32'(out_fill) >= k) begin
        taps_mux[tap_lsb(k, DATA_W) +: DATA_W] = rd_word[tap_lsb(k, DATA_W) +: DATA_W];
      end
`ifdef LINE_BUF_BORDER_REPLICATE_EN
      else if (out_fill == '0) begin
        taps_mux[tap_lsb(k, DATA_W) +: DATA_W] = cur_q;
      end else begin
        taps_mux[tap_lsb(k, DATA_W) +: DATA_W] = rd_word[tap_lsb(32'(out_fill), DATA_W) +: DATA_W];
      end
`endif
    end
  end

  assign bus.dout_cur  = cur_q;
  assign bus.taps      = taps_mux;
  assign bus.out_vld   = vld_q;
  assign bus.taps_full = full_q;
  assign bus.col_cnt   = out_col;
  assign bus.row_cnt   = out_row;

endmodule

// File: tb/tb_line_buffer_taps.sv
// Directed bench for line_buffer_taps with LINE_LEN=8, NUM_TAPS=2; honours LINE_BUF_BORDER_REPLICATE_EN.
module tb_line_buffer_taps;

  localparam int unsigned DW = 8;
  localparam int unsigned LL = 8;
  localparam int unsigned NT = 2;

  logic clk = 1'b0;
  logic Reset_n;
  always #5 clk = ~clk;

  line_buffer_taps_if #(.DATA_W(DW), .LINE_LEN(LL), .NUM_TAPS(NT)) bus ();

  line_buffer_taps #(.DATA_W(DW), .LINE_LEN(LL), .NUM_TAPS(NT)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         r;
    int         c;
    logic [7:0] cur;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       full;
  } vec_t;

  vec_t tbl[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic vec_t mk(int r, int c, logic [7:0] cur, logic [7:0] t1z, logic [7:0] t2z,
                              logic [7:0] t1r, logic [7:0] t2r, logic full);
    vec_t v;
    v.r = r; v.c = c; v.cur = cur; v.full = full;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
    v.t1 = t1r; v.t2 = t2r;
`else
    v.t1 = t1z; v.t2 = t2z;
`endif
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_taps(input string nm, input vec_t v);
    check({nm, ".cur"},  32'(bus.dout_cur),  32'(v.cur));
    check({nm, ".tap1"}, 32'(bus.taps[7:0]),  32'(v.t1));
    check({nm, ".tap2"}, 32'(bus.taps[15:8]), 32'(v.t2));
    check({nm, ".full"}, 32'(bus.taps_full), 32'(v.full));
  endtask

  // Accept one pixel, check position/latency, compare any table entry for (r,c), then idle 'gaps' cycles.
  task automatic pixel(input logic s, input logic [7:0] d, input int r, input int c, input int gaps);
    int hit;
    string nm;
    hit = -1;
    bus.clken = 1'b1; bus.sof = s; bus.din = d;
    @(posedge clk); #1;
    bus.clken = 1'b0; bus.sof = 1'b0; bus.din = 8'($urandom);
    nm = $sformatf("r%0dc%0d", r, c);
    check({nm, ".vld"}, 32'(bus.out_vld), 32'd1);
    check({nm, ".dout"}, 32'(bus.dout_cur), 32'(d));
    check({nm, ".col"}, 32'(bus.col_cnt), 32'(c));
    check({nm, ".row"}, 32'(bus.row_cnt), 32'(r));
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].r == r && tbl[i].c == c) begin
        hit = i;
        check_taps(nm, tbl[i]);
      end
    for (int g = 0; g < gaps; g++) begin
      bus.sof = 1'b1;  // must be ignored without clken
      @(posedge clk); #1;
      bus.sof = 1'b0;
      check({nm, ".gap_vld"}, 32'(bus.out_vld), 32'd0);
      check({nm, ".gap_dout"}, 32'(bus.dout_cur), 32'(d));
      check({nm, ".gap_col"}, 32'(bus.col_cnt), 32'(c));
      if (hit >= 0) check_taps({nm, ".gap"}, tbl[hit]);
    end
  endtask

  task automatic run(input int r0, input int c0, input int r1, input int c1, input logic [7:0] base,
                     input bit first_sof, input bit gapped, input bit chk_empty);
    int n;
    n = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = (r == r0) ? c0 : 0; c <= ((r == r1) ? c1 : int'(LL) - 1); c++) begin
        pixel(first_sof && r == r0 && c == c0, 8'(int'(base) + r * 16 + c), r, c,
              (gapped && (n % 2 == 0)) ? 2 : 0);
        if (chk_empty && r < 2) check($sformatf("r%0dc%0d.notfull", r, c), 32'(bus.taps_full), 32'd0);
        n++;
      end
  endtask

  task automatic check_idle_zero(input string nm);
    check({nm, ".vld"},  32'(bus.out_vld),   32'd0);
    check({nm, ".dout"}, 32'(bus.dout_cur),  32'd0);
    check({nm, ".taps"}, 32'(bus.taps),      32'd0);
    check({nm, ".col"},  32'(bus.col_cnt),   32'd0);
    check({nm, ".row"},  32'(bus.row_cnt),   32'd0);
    check({nm, ".full"}, 32'(bus.taps_full), 32'd0);
  endtask

  initial begin
    bus.clken = 1'b1; bus.sof = 1'b0; bus.din = 8'hFF;
    Reset_n = 1'b0;

    // reset held two clocks with clken high
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    bus.clken = 1'b0;
    Reset_n = 1'b1;
    @(posedge clk); #1;

    // continuous fill
    tbl.delete();
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(0, 7, 8'h07, 8'h00, 8'h00, 8'h07, 8'h07, 1'b0));
    tbl.push_back(mk(1, 0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1, 2, 8'h12, 8'h02, 8'h00, 8'h02, 8'h02, 1'b0));
    tbl.push_back(mk(1, 5, 8'h15, 8'h05, 8'h00, 8'h05, 8'h05, 1'b0));
    tbl.push_back(mk(2, 3, 8'h23, 8'h13, 8'h03, 8'h13, 8'h03, 1'b1));
    tbl.push_back(mk(2, 7, 8'h27, 8'h17, 8'h07, 8'h17, 8'h07, 1'b1));
    tbl.push_back(mk(3, 0, 8'h30, 8'h20, 8'h10, 8'h20, 8'h10, 1'b1));
    run(0, 0, 3, 0, 8'h00, 1'b1, 1'b0, 1'b1);

    // same frame with clken gaps (1,0,0,1 pattern) and stray sof in the gaps
    run(0, 0, 3, 0, 8'h00, 1'b1, 1'b1, 1'b1);

    // mid-frame sof at row3 col5
    tbl.delete();
    run(0, 0, 3, 4, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl.push_back(mk(0, 0, 8'h35, 8'h00, 8'h00, 8'h35, 8'h35, 1'b0));
    tbl.push_back(mk(1, 7, 8'h17, 8'h07, 8'h00, 8'h07, 8'h07, 1'b0));
    tbl.push_back(mk(2, 0, 8'h20, 8'h10, 8'h35, 8'h10, 8'h35, 1'b1));
    tbl.push_back(mk(2, 1, 8'h21, 8'h11, 8'h01, 8'h11, 8'h01, 1'b1));
    pixel(1'b1, 8'h35, 0, 0, 0);
    check("sof.notfull", 32'(bus.taps_full), 32'd0);
    run(0, 1, 2, 1, 8'h00, 1'b0, 1'b0, 1'b1);

    // reset mid-line at row2 col4, restart with sof and fresh data
    tbl.delete();
    run(0, 0, 2, 4, 8'h00, 1'b1, 1'b0, 1'b0);
    Reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("midreset");
    Reset_n = 1'b1;
    tbl.push_back(mk(0, 3, 8'h83, 8'h00, 8'h00, 8'h83, 8'h83, 1'b0));
    tbl.push_back(mk(1, 4, 8'h94, 8'h84, 8'h00, 8'h84, 8'h84, 1'b0));
    tbl.push_back(mk(2, 0, 8'hA0, 8'h90, 8'h80, 8'h90, 8'h80, 1'b1));
    tbl.push_back(mk(2, 4, 8'hA4, 8'h94, 8'h84, 8'h94, 8'h84, 1'b1));
    run(0, 0, 2, 4, 8'h80, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
